// File: rtl/eight_output_demux_pkg.sv
// Shared types and sizes for the eight-way valid/ready demultiplexer.
package eight_output_demux_pkg;

   localparam int unsigned NUM_PORTS = 8;
   localparam int unsigned SEL_W     = 3;

   typedef logic [SEL_W-1:0] port_sel_t;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } demux_state_t;

endpackage

// File: rtl/eight_output_demux_out_slice.sv
// One-entry full-throughput valid/ready register feeding a single output stream.
module demux_out_slice #(
   parameter int unsigned WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] d_data,
   input  logic             d_last,
   output logic             valid,
   input  logic             ready,
   output logic [WIDTH-1:0] q_data,
   output logic             q_last,
   output logic             slot_ready
);

   // Slot can take a new beat when empty or when its current beat drains this cycle.
   assign slot_ready = !valid || ready;

   // A load wins over a drain, so a same-cycle drain+load keeps valid high.
   // Payload changes only on a load and is left in place when the slot empties.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid  <= 1'b0;
         q_data <= '0;
         q_last <= 1'b0;
      end else if (load) begin
         valid  <= 1'b1;
         q_data <= d_data;
         q_last <= d_last;
      end else if (ready) begin
         valid  <= 1'b0;
      end
   end

endmodule

// File: rtl/eight_output_demux.sv
// Routes one valid/ready packet stream to one of eight outputs, holding the route for a whole packet.
module eight_output_demux
   import eight_output_demux_pkg::*;
#(
   parameter int unsigned WIDTH = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   input  port_sel_t            in_select,
   input  logic                 in_last,
   output logic [NUM_PORTS-1:0] out_valid,
   input  logic [NUM_PORTS-1:0] out_ready,
   output logic [WIDTH-1:0]     out_data [NUM_PORTS],
   output logic [NUM_PORTS-1:0] out_last,
   output logic                 busy
);

   demux_state_t          state;
   port_sel_t             lock_sel;
   port_sel_t             dest;
   logic                  accept;
   logic [NUM_PORTS-1:0]  slot_ready;
   logic [NUM_PORTS-1:0]  load;

   // in_select only matters on a packet's first beat; later beats follow the lock.
   assign dest     = (state == LOCKED) ? lock_sel : in_select;
   assign in_ready = slot_ready[dest];
   assign accept   = in_valid && in_ready;
   assign busy     = (state == LOCKED);

   // Packet lock: a multi-beat packet captures its destination until its last beat is taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         lock_sel <= '0;
      end else if (accept) begin
         case (state)
            IDLE: begin
               if (!in_last) begin
                  lock_sel <= in_select;
                  state    <= LOCKED;
               end
            end
            LOCKED: begin
               if (in_last) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_slice
      assign load[i] = accept && (dest == port_sel_t'(i));

      demux_out_slice #(.WIDTH(WIDTH)) u_slice (
         .clk        (clk),
         .rst_n      (rst_n),
         .load       (load[i]),
         .d_data     (in_data),
         .d_last     (in_last),
         .valid      (out_valid[i]),
         .ready      (out_ready[i]),
         .q_data     (out_data[i]),
         .q_last     (out_last[i]),
         .slot_ready (slot_ready[i])
      );
   end

endmodule

// File: tb/tb_eight_output_demux.sv
// Vector-table bench for eight_output_demux with a per-output scoreboard of expected beats.
module tb_eight_output_demux;
   import eight_output_demux_pkg::*;

   localparam int unsigned WIDTH = 64;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     in_data;
   port_sel_t            in_select;
   logic                 in_last;
   logic [NUM_PORTS-1:0] out_valid;
   logic [NUM_PORTS-1:0] out_ready;
   logic [WIDTH-1:0]     out_data [NUM_PORTS];
   logic [NUM_PORTS-1:0] out_last;
   logic                 busy;

   eight_output_demux #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_select (in_select),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic           v;
      port_sel_t      sel;
      logic [63:0]    data;
      logic           last;
      logic [7:0]     ordy;
      logic           e_rdy;   // expected in_ready while the vector is presented
      port_sel_t      e_dest;  // output the beat must appear on if accepted
      logic [7:0]     e_ov;    // expected out_valid after the edge
      logic           e_busy;  // expected busy after the edge
   } vec_t;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             last;
   } beat_t;

   vec_t  vecs [$];
   beat_t sb [NUM_PORTS][$];
   int    n_vec  = 0;
   int    n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic void add(input logic v, input int sel, input logic [63:0] d, input logic l,
                               input logic [7:0] ordy, input logic er, input int ed,
                               input logic [7:0] eov, input logic eb);
      vec_t x;
      x.v = v; x.sel = port_sel_t'(sel); x.data = d; x.last = l; x.ordy = ordy;
      x.e_rdy = er; x.e_dest = port_sel_t'(ed); x.e_ov = eov; x.e_busy = eb;
      vecs.push_back(x);
   endfunction

   // Drive at the falling edge, compare in_ready and drained beats, then check state after the rise.
   task automatic apply(input vec_t x, input int idx);
      beat_t b;
      in_valid  = x.v;
      in_select = x.sel;
      in_data   = x.data;
      in_last   = x.last;
      out_ready = x.ordy;
      #1;
      check($sformatf("in_ready v%0d", idx), 64'(in_ready), 64'(x.e_rdy));
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (out_valid[i] && out_ready[i]) begin
            if (sb[i].size() == 0) begin
               n_vec++;
               n_fail++;
               $display("FAIL unexpected beat v%0d out%0d: got %0h, expected none", idx, i, out_data[i]);
            end else begin
               b = sb[i].pop_front();
               check($sformatf("out_data[%0d] v%0d", i, idx), out_data[i], b.data);
               check($sformatf("out_last[%0d] v%0d", i, idx), 64'(out_last[i]), 64'(b.last));
            end
         end
      end
      if (x.v && x.e_rdy) sb[x.e_dest].push_back({x.data, x.last});
      @(posedge clk);
      #1;
      check($sformatf("out_valid v%0d", idx), 64'(out_valid), 64'(x.e_ov));
      check($sformatf("busy v%0d", idx), 64'(busy), 64'(x.e_busy));
      @(negedge clk);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_select = '0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 8'hFF;
      repeat (2) @(negedge clk);
      check("reset out_valid", 64'(out_valid), 64'h0);
      check("reset out_last", 64'(out_last), 64'h0);
      check("reset busy", 64'(busy), 64'h0);
      check("reset out_data[0]", out_data[0], 64'h0);
      check("reset out_data[7]", out_data[7], 64'h0);
      check("reset in_ready", 64'(in_ready), 64'h1);
      rst_n = 1'b1;
      @(negedge clk);

      // Single beat to output 5
      add(1, 5, 64'hA5A5, 1, 8'hFF, 1, 5, 8'h20, 0);
      add(0, 0, 64'h0,    0, 8'hFF, 1, 0, 8'h00, 0);
      // Four-beat packet locked to output 2 while in_select moves to 6
      add(1, 2, 64'h1001, 0, 8'hFF, 1, 2, 8'h04, 1);
      add(1, 6, 64'h1002, 0, 8'hFF, 1, 2, 8'h04, 1);
      add(1, 6, 64'h1003, 0, 8'hFF, 1, 2, 8'h04, 1);
      add(1, 6, 64'h1004, 1, 8'hFF, 1, 2, 8'h04, 0);
      add(0, 0, 64'h0,    0, 8'hFF, 1, 0, 8'h00, 0);
      // Backpressure on output 3, then release with no bubble
      add(1, 3, 64'h3001, 1, 8'hF7, 1, 3, 8'h08, 0);
      add(1, 3, 64'h3002, 1, 8'hF7, 0, 3, 8'h08, 0);
      add(1, 3, 64'h3002, 1, 8'hF7, 0, 3, 8'h08, 0);
      add(1, 3, 64'h3002, 1, 8'hFF, 1, 3, 8'h08, 0);
      add(0, 0, 64'h0,    0, 8'hFF, 1, 0, 8'h00, 0);
      // Stalled output 1 must not block output 4
      add(1, 1, 64'h4001, 1, 8'hFD, 1, 1, 8'h02, 0);
      add(1, 4, 64'h4004, 1, 8'hFD, 1, 4, 8'h12, 0);
      add(0, 0, 64'h0,    0, 8'hFD, 1, 0, 8'h02, 0);
      add(0, 0, 64'h0,    0, 8'hFF, 1, 0, 8'h00, 0);
      // Back-to-back single-beat packets sweeping every output
      for (int d = 0; d < NUM_PORTS; d++)
         add(1, d, 64'h5000 + 64'(d), 1, 8'hFF, 1, d, 8'(1 << d), 0);
      add(0, 0, 64'h0,    0, 8'hFF, 1, 0, 8'h00, 0);
      // Fill slots 7 and 0 with a packet left open on output 0
      add(1, 7, 64'h6007, 1, 8'h00, 1, 7, 8'h80, 0);
      add(1, 0, 64'h6000, 0, 8'h00, 1, 0, 8'h81, 1);

      foreach (vecs[k]) apply(vecs[k], k);

      // Asynchronous reset mid-packet between clock edges
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("async reset out_valid", 64'(out_valid), 64'h0);
      check("async reset busy", 64'(busy), 64'h0);
      for (int i = 0; i < NUM_PORTS; i++) sb[i].delete();
      @(negedge clk);
      rst_n = 1'b1;
      vecs.delete();
      // Lock released: the beat follows its own select, not the stale lock to 0
      add(1, 6, 64'h6006, 1, 8'hFF, 1, 6, 8'h40, 0);
      add(0, 0, 64'h0,    0, 8'hFF, 1, 0, 8'h00, 0);
      foreach (vecs[k]) apply(vecs[k], 100 + k);

      for (int i = 0; i < NUM_PORTS; i++)
         check($sformatf("leftover beats out%0d", i), 64'(sb[i].size()), 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
